// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: LC3 instruction-fetch unit. Owns the program counter,
// prefetches sequential instructions over a req/gnt/rvalid memory port (at most
// one request outstanding) into a DEPTH-entry queue that feeds decode.
//
// Handshakes:
//   memory : mem_req is a combinational offer; the request is taken on a cycle
//            where mem_req & mem_gnt. Its data comes back on a later cycle with
//            mem_rvalid. mem_gnt is ignored while mem_req is low.
//   decode : the head entry is transferred on a cycle where out_valid &
//            out_ready. out_valid never depends on out_ready.
// A redirect flushes the queue, reloads the PC and discards any in-flight
// response; it takes priority over a same-cycle push or pop.
module fetch_prefetch_queue #(
    parameter int              AW       = 16,
    parameter int              DW       = 16,
    parameter int              DEPTH    = 4,
    parameter logic [AW-1:0]   RESET_PC = 16'h3000
) (
    input  logic          clk,
    input  logic          rst,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    input  logic          stall_mem,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          out_valid,
    output logic [DW-1:0] out_instr,
    output logic [AW-1:0] out_pc,
    output logic [AW-1:0] out_npc,
    input  logic          out_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    // IDLE: may request; WAIT: response pending and wanted;
    // DRAIN: response pending but will be thrown away.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]    state_q,     state_d;
    logic [AW-1:0] fetch_pc_q,  fetch_pc_d;
    logic [AW-1:0] issued_pc_q, issued_pc_d;
    logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
    logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [CW-1:0] count_q,     count_d;
    logic [DW-1:0] instr_q [DEPTH];
    logic [DW-1:0] instr_d [DEPTH];
    logic [AW-1:0] pc_q    [DEPTH];
    logic [AW-1:0] pc_d    [DEPTH];

    logic push;
    logic pop;

    // Request offer, queue handshake qualifiers and head-of-queue outputs.
    always_comb begin
        mem_req   = rst && (state_q == ST_IDLE) && (count_q < DEPTH_CNT)
                    && !stall_mem && !redirect;
        mem_addr  = fetch_pc_q;
        push      = (state_q == ST_WAIT) && mem_rvalid && !redirect;
        out_valid = (count_q != '0);
        pop       = out_valid && out_ready && !redirect;
        out_instr = instr_q[rd_ptr_q];
        out_pc    = pc_q[rd_ptr_q];
        out_npc   = pc_q[rd_ptr_q] + AW'(1);
    end

    // Next-state for the fetch FSM and the program counter.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        issued_pc_d = issued_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (mem_req && mem_gnt) begin
            fetch_pc_d  = fetch_pc_q + AW'(1);
            issued_pc_d = fetch_pc_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (mem_req && mem_gnt) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rvalid)    state_d = ST_IDLE;
                else if (redirect) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (mem_rvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next-state for queue pointers, occupancy and storage.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        instr_d  = instr_q;
        pc_d     = pc_q;
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                instr_d[wr_ptr_q] = mem_rdata;
                pc_d[wr_ptr_q]    = issued_pc_q;
                wr_ptr_d          = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_PC;
            issued_pc_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: scenario tasks plus a randomized run, all checked
// against a transaction-level model (expected queue of PCs, model PC, one
// outstanding-request flag) and a bench memory whose data is a function of
// the address.
module tb_fetch_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        stall_mem;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic [15:0] out_npc;
    logic        out_ready;

    fetch_prefetch_queue #(
        .AW(16), .DW(16), .DEPTH(DEPTH), .RESET_PC(16'h3000)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_mem(stall_mem), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_npc(out_npc), .out_ready(out_ready)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard / model state
    int          total;
    int          bad;
    logic [15:0] exp_q[$];      // PCs currently expected in the instruction queue
    logic [15:0] issue_log[$];  // addresses the model expects to be issued
    logic [15:0] pop_log[$];    // PCs the model expects decode to consume
    logic [15:0] npc_log[$];    // DUT out_npc seen on each consume
    logic [15:0] mdl_pc;
    logic [15:0] pend_pc;
    logic [15:0] pend_addr;
    bit          outstanding;
    bit          discard;
    int          cd;
    logic [15:0] salt;

    function automatic logic [15:0] memfun(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ salt;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        mdl_pc      = 16'h3000;
        outstanding = 0;
        discard     = 0;
        cd          = 0;
    endtask

    // driver: async reset pulse with the memory side idle
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; out_ready = 1'b0;
        stall_mem = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic gnt, input logic rdy, input logic stl,
                        input logic redir, input logic [15:0] rpc, input int lat);
        logic rv, exp_req, exp_valid, issued, popped;
        logic [15:0] hp, hnpc;
        @(negedge clk);
        rv          = outstanding && (cd == 0);
        mem_gnt     = gnt;
        out_ready   = rdy;
        stall_mem   = stl;
        redirect    = redir;
        redirect_pc = rpc;
        mem_rvalid  = rv;
        mem_rdata   = rv ? memfun(pend_addr) : 16'($urandom());
        #1;
        exp_req   = !outstanding && (exp_q.size() < DEPTH) && !stl && !redir;
        exp_valid = (exp_q.size() != 0);
        total++;
        if (mem_req !== exp_req) begin
            bad++; $display("FAIL mem_req t=%0t got=%b exp=%b", $time, mem_req, exp_req);
        end
        total++;
        if (mem_addr !== mdl_pc) begin
            bad++; $display("FAIL mem_addr t=%0t got=%h exp=%h", $time, mem_addr, mdl_pc);
        end
        total++;
        if (out_valid !== exp_valid) begin
            bad++; $display("FAIL out_valid t=%0t got=%b exp=%b", $time, out_valid, exp_valid);
        end
        if (exp_valid) begin
            hp   = exp_q[0];
            hnpc = hp + 16'd1;
            total++;
            if (out_pc !== hp) begin
                bad++; $display("FAIL out_pc t=%0t got=%h exp=%h", $time, out_pc, hp);
            end
            total++;
            if (out_instr !== memfun(hp)) begin
                bad++; $display("FAIL out_instr t=%0t got=%h exp=%h", $time, out_instr, memfun(hp));
            end
            total++;
            if (out_npc !== hnpc) begin
                bad++; $display("FAIL out_npc t=%0t got=%h exp=%h", $time, out_npc, hnpc);
            end
        end
        issued = exp_req && gnt;
        popped = exp_valid && rdy && !redir;
        if (issued) issue_log.push_back(mdl_pc);
        if (popped) begin
            pop_log.push_back(exp_q[0]);
            npc_log.push_back(out_npc);
        end
        // clock edge, as seen by the model
        if (redir) begin
            exp_q.delete();
            mdl_pc = rpc;
        end else if (popped) begin
            void'(exp_q.pop_front());
        end
        if (rv) begin
            if (!redir && !discard) exp_q.push_back(pend_pc);
            outstanding = 0;
            discard     = 0;
        end else if (outstanding) begin
            cd--;
            if (redir) discard = 1;
        end
        if (issued) begin
            pend_pc     = mdl_pc;
            pend_addr   = mem_addr;
            mdl_pc      = mdl_pc + 16'd1;
            outstanding = 1;
            discard     = 0;
            cd          = lat - 1;
        end
    endtask

    task automatic clear_logs();
        issue_log.delete();
        pop_log.delete();
        npc_log.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; mem_gnt = 1'b1; stall_mem = 1'b0; redirect = 1'b0;
        out_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 16'h0; redirect_pc = 16'h0;
        model_reset();
        #1;
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++;
        if (mem_addr !== 16'h3000) begin bad++; $display("FAIL reset_mem_addr got=%h exp=3000", mem_addr); end
        total++;
        if (out_pc !== 16'h0) begin bad++; $display("FAIL reset_out_pc got=%h exp=0000", out_pc); end
        total++;
        if (out_instr !== 16'h0) begin bad++; $display("FAIL reset_out_instr got=%h exp=0000", out_instr); end
        @(negedge clk);
        rst = 1'b1; mem_gnt = 1'b0;
    endtask

    task automatic test_sequential();
        clear_logs();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1);
        total++;
        if (pop_log.size() < 8) begin
            bad++; $display("FAIL seq_pops got=%0d exp>=8", pop_log.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (pop_log[i] !== 16'(16'h3000 + i)) begin
                    bad++; $display("FAIL seq_order idx=%0d got=%h exp=%h", i, pop_log[i], 16'(16'h3000 + i));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        clear_logs();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1);
        total++;
        if (issue_log.size() != DEPTH) begin
            bad++; $display("FAIL bp_issues got=%0d exp=%0d", issue_log.size(), DEPTH);
        end
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL bp_req_full got=%b exp=0", mem_req); end
        clear_logs();
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1);
        total++;
        if (pop_log.size() != DEPTH) begin
            bad++; $display("FAIL bp_pops got=%0d exp=%0d", pop_log.size(), DEPTH);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1);
        total++;
        if (issue_log.size() != 1 || issue_log[0] !== 16'h3004) begin
            bad++; $display("FAIL bp_resume got=%h exp=3004", (issue_log.size() != 0) ? issue_log[0] : 16'hxxxx);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1);
    endtask

    task automatic test_redirect_wait();
        do_reset();
        clear_logs();
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 3);      // issue 0x3000, data in 3 cycles
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h4000, 1);   // redirect while waiting
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1);      // stale response arrives here
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rw_empty got=%b exp=0", out_valid); end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1);
        total++;
        if (issue_log.size() < 2 || issue_log[1] !== 16'h4000) begin
            bad++; $display("FAIL rw_next_addr got=%h exp=4000", (issue_log.size() > 1) ? issue_log[1] : 16'hxxxx);
        end
        total++;
        if (pop_log.size() == 0 || pop_log[0] !== 16'h4000) begin
            bad++; $display("FAIL rw_next_pc got=%h exp=4000", (pop_log.size() != 0) ? pop_log[0] : 16'hxxxx);
        end
    endtask

    task automatic test_redirect_rvalid();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1);
        total++;
        if (exp_q.size() != 2 || out_valid !== 1'b1) begin
            bad++; $display("FAIL rr_fill got=%b exp=1 entries=%0d", out_valid, exp_q.size());
        end
        clear_logs();
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h5000, 1);   // redirect together with rvalid
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rr_flush got=%b exp=0", out_valid); end
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h5000) begin
            bad++; $display("FAIL rr_req got=%b/%h exp=1/5000", mem_req, mem_addr);
        end
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1);
        total++;
        if (pop_log.size() == 0 || pop_log[0] !== 16'h5000) begin
            bad++; $display("FAIL rr_next_pc got=%h exp=5000", (pop_log.size() != 0) ? pop_log[0] : 16'hxxxx);
        end
    endtask

    task automatic test_stall();
        logic [15:0] held;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1);  // settle in IDLE
        held = mdl_pc;
        clear_logs();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 1);
            total++;
            if (mem_req !== 1'b0 || mem_addr !== held) begin
                bad++; $display("FAIL stall_hold got=%b/%h exp=0/%h", mem_req, mem_addr, held);
            end
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1);
        total++;
        if (issue_log.size() != 1 || issue_log[0] !== held) begin
            bad++; $display("FAIL stall_release got=%h exp=%h", (issue_log.size() != 0) ? issue_log[0] : 16'hxxxx, held);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1);  // let any drain finish
        clear_logs();
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1);
        total++;
        if (pop_log.size() < 2 || pop_log[0] !== 16'hFFFF || pop_log[1] !== 16'h0000) begin
            bad++; $display("FAIL wrap_order got=%0d pops exp=FFFF,0000 first", pop_log.size());
        end
        total++;
        if (npc_log.size() == 0 || npc_log[0] !== 16'h0000) begin
            bad++; $display("FAIL wrap_npc got=%h exp=0000", (npc_log.size() != 0) ? npc_log[0] : 16'hxxxx);
        end
    endtask

    task automatic test_reset_midflight();
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 4);
        do_reset();
        clear_logs();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1);
        total++;
        if (pop_log.size() == 0 || pop_log[0] !== 16'h3000) begin
            bad++; $display("FAIL midreset_pc got=%h exp=3000", (pop_log.size() != 0) ? pop_log[0] : 16'hxxxx);
        end
    endtask

    task automatic test_random();
        logic [15:0] rpc;
        for (int i = 0; i < 1500; i++) begin
            rpc = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFE + $urandom_range(0, 2)) : 16'($urandom());
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 15) == 0, rpc, $urandom_range(1, 4));
        end
    endtask

    initial begin
        total = 0; bad = 0;
        salt = 16'($urandom());
        rst = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h0;
        stall_mem = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; out_ready = 1'b0;
        model_reset();
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rvalid();
        test_stall();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
